// File: rtl/fir_xifu_ctrl.sv
// In-order issue/commit scheduler for the FIR XIFU coprocessor with a 32-bit register scoreboard.
// Define FIR_XIFU_CTRL_HAZARD_EN to let scoreboard hazards (RAW/WAW) backpressure issue.
module fir_xifu_ctrl #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic [ID_WIDTH-1:0]        issue_id_i,
  input  logic [4:0]                 issue_rd_i,
  input  logic [4:0]                 issue_rs1_i,
  input  logic [4:0]                 issue_rs2_i,
  input  logic                       issue_rd_we_i,
  input  logic                       issue_rs_re_i,
  input  logic                       commit_valid_i,
  input  logic [ID_WIDTH-1:0]        commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       disp_valid_o,
  input  logic                       disp_ready_i,
  output logic [ID_WIDTH-1:0]        disp_id_o,
  input  logic                       done_valid_i,
  input  logic [4:0]                 done_rd_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       busy_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef enum logic [1:0] {ST_FREE, ST_ISSUED, ST_COMMITTED, ST_KILLED} ent_state_e;

  ent_state_e           state_q [DEPTH];
  logic [ID_WIDTH-1:0]  id_q    [DEPTH];
  logic [4:0]           rd_q    [DEPTH];
  logic                 rd_we_q [DEPTH];
  logic [PW-1:0]        head_q, tail_q;
  logic [31:0]          sb_q, sb_d;

  logic [IW-1:0] head_idx, tail_idx, cm_idx;
  logic [PW-1:0] count;
  logic          full, hazard, push, pop_disp, pop_kill, pop, cm_hit, bypass;

  assign head_idx = head_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];
  assign count    = tail_q - head_q;
  assign full     = (count == PW'(DEPTH));

`ifdef FIR_XIFU_CTRL_HAZARD_EN
  assign hazard = (issue_rs_re_i && (sb_q[issue_rs1_i] || sb_q[issue_rs2_i])) ||
                  (issue_rd_we_i && sb_q[issue_rd_i]);
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{issue_rs1_i, issue_rs2_i, issue_rs_re_i};
  assign hazard = 1'b0;
`endif

  assign issue_ready_o = !full && !hazard;
  assign push          = issue_valid_i && issue_ready_o;
  assign disp_valid_o  = (state_q[head_idx] == ST_COMMITTED);
  assign disp_id_o     = id_q[head_idx];
  assign pop_disp      = disp_valid_o && disp_ready_i;
  assign pop_kill      = (state_q[head_idx] == ST_KILLED);
  assign pop           = pop_disp || pop_kill;
  assign count_o       = count;
  assign busy_o        = (count != '0) || (sb_q != '0);

  // Ids are unique while in flight, so at most one ISSUED entry can match.
  always_comb begin
    cm_hit = 1'b0;
    cm_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == ST_ISSUED && id_q[i] == commit_id_i) begin
        cm_hit = 1'b1;
        cm_idx = IW'(i);
      end
    end
  end

  assign bypass = commit_valid_i && push && !cm_hit && (issue_id_i == commit_id_i);

  // Clears first, then the issue set, so a same-cycle set wins.
  always_comb begin
    sb_d = sb_q;
    if (done_valid_i)
      sb_d[done_rd_i] = 1'b0;
    if (pop_kill && rd_we_q[head_idx])
      sb_d[rd_q[head_idx]] = 1'b0;
    if (push && issue_rd_we_i)
      sb_d[issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_FREE;
        id_q[i]    <= '0;
        rd_q[i]    <= '0;
        rd_we_q[i] <= 1'b0;
      end
      head_q <= '0;
      tail_q <= '0;
      sb_q   <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < DEPTH; i++)
        state_q[i] <= ST_FREE;
      head_q <= '0;
      tail_q <= '0;
      sb_q   <= '0;
    end else begin
      // A push never lands on the head slot being popped: the tail slot is FREE.
      if (push) begin
        if (bypass)
          state_q[tail_idx] <= commit_kill_i ? ST_KILLED : ST_COMMITTED;
        else
          state_q[tail_idx] <= ST_ISSUED;
        id_q[tail_idx]    <= issue_id_i;
        rd_q[tail_idx]    <= issue_rd_i;
        rd_we_q[tail_idx] <= issue_rd_we_i;
        tail_q            <= tail_q + PW'(1);
      end
      if (commit_valid_i && cm_hit)
        state_q[cm_idx] <= commit_kill_i ? ST_KILLED : ST_COMMITTED;
      if (pop) begin
        state_q[head_idx] <= ST_FREE;
        head_q            <= head_q + PW'(1);
      end
      sb_q <= sb_d;
    end
  end

endmodule
